hazard_stall_controller: RTL
============================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AddressSize, 5, register-address width; MUL_LATENCY, 3, cycles a multiply occupies EX (legal range 2..16); CNT_WIDTH, 16, performance-counter width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 arst_n  in  1  reset, synchronous and active-low.
REQ-004 id_rs1, id_rs2  in  AddressSize  source registers of the instruction in ID.
REQ-005 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-006 id_is_branch  in  1  ID instruction is a branch, compared in ID.
REQ-007 id_branch_taken  in  1  ID compare result, valid when id_is_branch=1.
REQ-008 ex_rd  in  AddressSize; ex_reg_write  in  1; ex_mem_read  in  1  EX destination, write-enable and load flag.
REQ-009 ex_mul_start  in  1  EX holds a multiply; stays high while the multiply sits in EX.
REQ-010 mem_rd  in  AddressSize; mem_mem_read  in  1  MEM destination and load flag.
REQ-011 pc_write, if_id_write, id_ex_write  out  1 each  pipeline-register enables (1 = advance).
REQ-012 id_ex_bubble, ex_mem_bubble  out  1 each  insert NOP into ID/EX or EX/MEM.
REQ-013 if_id_flush  out  1  squash the fetched instruction.
REQ-014 stall_cycles, flush_count  out  CNT_WIDTH each  performance counters.
REQ-015 busy  out  1  high while state is MUL_WAIT.

Function
REQ-016 Register 0 SHALL never cause a hazard; every rd comparison below requires rd!=0.
REQ-017 match_ex SHALL be (ex_rd==id_rs1) or (id_uses_rs2 and ex_rd==id_rs2); match_mem SHALL be the same test on mem_rd.
REQ-018 load_use SHALL be ex_mem_read and match_ex.
REQ-019 branch_haz SHALL be id_is_branch and ((ex_reg_write and match_ex) or (mem_mem_read and match_mem)).
REQ-020 FSM states SHALL be RUN and MUL_WAIT, with a down-counter mcnt (4 bits).
REQ-021 In RUN with ex_mul_start=1, the next state SHALL be MUL_WAIT and mcnt SHALL load MUL_LATENCY-2.
REQ-022 In MUL_WAIT, mcnt SHALL decrement while non-zero; at mcnt==0 the next state SHALL be RUN; ex_mul_start SHALL be ignored in MUL_WAIT.
REQ-023 mul_stall SHALL be (RUN and ex_mul_start) or (MUL_WAIT and mcnt!=0); this gives MUL_LATENCY-1 stall cycles per multiply.
REQ-024 If mul_stall: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, id_ex_bubble=0, if_id_flush=0; ID hazards SHALL be ignored.
REQ-025 Otherwise, if load_use or branch_haz: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, ex_mem_bubble=0, if_id_flush=0.
REQ-026 Otherwise, if id_is_branch and id_branch_taken: all enables=1, if_id_flush=1, both bubbles=0.
REQ-027 Otherwise all enables SHALL be 1 and bubbles and flush SHALL be 0.
REQ-028 All control outputs SHALL be combinational in state, mcnt and inputs, with zero-cycle latency.
REQ-029 stall_cycles SHALL increment on each cycle with pc_write=0; flush_count SHALL increment on each cycle with if_id_flush=1; both SHALL saturate at all-ones, not wrap.
REQ-030 Load-then-branch on the same register SHALL naturally produce 2 stall cycles (EX load, then MEM load) with no extra state.

Reset
REQ-031 On a rising edge with arst_n=0: state=RUN, mcnt=0, stall_cycles=0 and flush_count=0, overriding any in-flight multiply.
REQ-032 After reset with idle inputs: pc_write=if_id_write=id_ex_write=1, bubbles=0, if_id_flush=0, busy=0.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_write=0 and id_ex_bubble=1 that cycle; stall_cycles=1.
REQ-034 id_is_branch=1, id_rs2=7, id_uses_rs2=1, with the load to r7 moving EX then MEM -> 2 stall cycles, then if_id_flush=1 when id_branch_taken=1; flush_count=1.
REQ-035 MUL_LATENCY=3, ex_mul_start high for 3 cycles -> 2 cycles of id_ex_write=0 and ex_mem_bubble=1; busy high for 2 cycles; 3rd cycle has all enables=1.
REQ-036 ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall.
REQ-037 arst_n=0 on the first MUL_WAIT cycle -> RUN next cycle, busy=0, counters=0.
REQ-038 Force 2^CNT_WIDTH+3 stall cycles -> stall_cycles holds 0xFFFF.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Purpose : in-order pipeline hazard unit: load-use / branch-operand stalls,
//           multi-cycle multiply freeze, taken-branch flush and perf counters.
// Latency : control outputs are combinational (zero cycle); counters update on clk.
// Backpressure: stalls hold PC and IF/ID; a multiply freezes ID/EX and bubbles EX/MEM.
//
// Ports:
//   clk, arst_n (synchronous, active-low)
//   id_*  : ID-stage sources, branch flag and compare result
//   ex_*  : EX destination, write-enable, load flag, multiply-in-EX flag
//   mem_* : MEM destination and load flag
//   pc_write / if_id_write / id_ex_write : pipeline register enables
//   id_ex_bubble / ex_mem_bubble / if_id_flush : NOP insertion and squash
//   stall_cycles / flush_count : saturating counters; busy : multiply in progress
module hazard_stall_controller #(
  parameter int AddressSize = 5,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [AddressSize-1:0] id_rs1,
  input  logic [AddressSize-1:0] id_rs2,
  input  logic                   id_uses_rs2,
  input  logic                   id_is_branch,
  input  logic                   id_branch_taken,
  input  logic [AddressSize-1:0] ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mul_start,
  input  logic [AddressSize-1:0] mem_rd,
  input  logic                   mem_mem_read,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic                   if_id_flush,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic [CNT_WIDTH-1:0]   flush_count,
  output logic                   busy
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // First multiply cycle is spent in RUN, so MUL_WAIT counts the remainder.
  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LATENCY - 2);

  state_t     state, state_nxt;
  logic [3:0] mcnt, mcnt_nxt;

  logic match_ex, match_mem;
  logic load_use, branch_haz, mul_stall;

  // r0 is hardwired zero, so a write to it never creates a dependency.
  assign match_ex  = (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign match_mem = (mem_rd != '0) &&
                     ((mem_rd == id_rs1) || (id_uses_rs2 && (mem_rd == id_rs2)));

  assign load_use = ex_mem_read && match_ex;
  // Branches resolve in ID, so they also wait for ALU results in EX and
  // loads in MEM; a load feeding a branch thus stalls twice on its own.
  assign branch_haz = id_is_branch &&
                      ((ex_reg_write && match_ex) || (mem_mem_read && match_mem));

  assign busy = (state == MUL_WAIT);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mcnt_nxt      = mcnt;
    mul_stall     = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;

    case (state)
      RUN: begin
        if (ex_mul_start) begin
          mul_stall = 1'b1;
          state_nxt = MUL_WAIT;
          mcnt_nxt  = MCNT_LOAD;
        end
      end
      MUL_WAIT: begin
        // ex_mul_start stays high for the whole multiply; ignore it here.
        if (mcnt != 4'd0) begin
          mul_stall = 1'b1;
          mcnt_nxt  = mcnt - 4'd1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        mcnt_nxt  = '0;
      end
    endcase

    if (mul_stall) begin
      // Multiply owns EX: freeze front end, drain a NOP into MEM.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (load_use || branch_haz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_is_branch && id_branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
